// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared types and constants for the memory controller
package mem_ctrl_pkg;

  typedef enum logic [1:0] {S_IDLE, S_IFETCH, S_LOAD, S_STORE} state_t;
  typedef enum logic {G_IF = 1'b0, G_LS = 1'b1} grant_t;

  localparam logic [1:0]  SZ_BYTE = 2'b00;
  localparam logic [1:0]  SZ_HALF = 2'b01;
  localparam logic [1:0]  SZ_WORD = 2'b10;
  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;

  // Reserved size code 11 moves a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_rr_arb.sv
// rtl/mem_rr_arb.sv - two-way round-robin picker
module mem_rr_arb
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] req,        // [0] instruction fetch, [1] load/store
  input  logic       last_grant, // 1 when load/store won the previous grant
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial RAM controller shared by instruction fetch and load/store
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_data,
  input  logic        ls_req,
  input  logic        ls_wr,
  input  logic [1:0]  ls_size,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  state_t      state;
  grant_t      last_grant;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic [31:0] rbuf_next;
  logic [2:0]  nbytes;
  logic [2:0]  ai;
  logic [2:0]  ci;
  logic        p1;
  logic        p2;
  logic [1:0]  grant;
  logic        stall;

  mem_rr_arb u_arb (
    .req        ({ls_req, if_req}),
    .last_grant (last_grant == G_LS),
    .grant      (grant)
  );

  // At the grant edge the address is still on the request port.
  assign stall = io_buffer_full &&
                 ((state == S_IDLE) ? (ls_addr >= IO_BASE) : (addr >= IO_BASE));

  always_comb begin
    rbuf_next = rbuf;
    rbuf_next[{ci[1:0], 3'b000} +: 8] = mem_din;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= S_IDLE;
      last_grant <= G_IF;
      addr       <= '0;
      wdata      <= '0;
      rbuf       <= '0;
      nbytes     <= '0;
      ai         <= '0;
      ci         <= '0;
      p1         <= 1'b0;
      p2         <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      mem_wr     <= 1'b0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      if_data    <= '0;
      ls_rdata   <= '0;
    end else if (!rdy_in) begin
      // Frozen: bytes in flight are lost, so rewind issue to the first uncaptured byte.
      mem_wr <= 1'b0;
      if (state == S_IFETCH || state == S_LOAD) begin
        ai <= ci;
        p1 <= 1'b0;
        p2 <= 1'b0;
      end
    end else begin
      if_done <= 1'b0;
      ls_done <= 1'b0;
      mem_wr  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (!clear_in && !if_done && !ls_done && grant != 2'b00) begin
            ci   <= '0;
            rbuf <= '0;
            p2   <= 1'b0;
            if (grant[1]) begin
              last_grant <= G_LS;
              addr       <= ls_addr;
              wdata      <= ls_wdata;
              nbytes     <= size_bytes(ls_size);
              mem_a      <= ls_addr;
              state      <= ls_wr ? S_STORE : S_LOAD;
            end else begin
              last_grant <= G_IF;
              addr       <= if_addr;
              nbytes     <= 3'd4;
              mem_a      <= if_addr;
              state      <= S_IFETCH;
            end
            if (grant[1] && ls_wr) begin
              p1 <= 1'b0;
              if (!stall) begin
                mem_dout <= ls_wdata[7:0];
                mem_wr   <= 1'b1;
                ai       <= 3'd1;
              end else begin
                ai <= 3'd0;
              end
            end else begin
              p1 <= 1'b1;
              ai <= 3'd1;
            end
          end
        end
        S_IFETCH, S_LOAD: begin
          if (clear_in) begin
            state <= S_IDLE;
            p1    <= 1'b0;
            p2    <= 1'b0;
          end else begin
            // p1: address on the bus this cycle; p2: its byte is on mem_din next cycle.
            p2 <= p1;
            if (ai < nbytes) begin
              mem_a <= addr + {29'd0, ai};
              ai    <= ai + 3'd1;
              p1    <= 1'b1;
            end else begin
              p1 <= 1'b0;
            end
            if (p2) begin
              rbuf <= rbuf_next;
              ci   <= ci + 3'd1;
              if (ci == nbytes - 3'd1) begin
                state <= S_IDLE;
                p1    <= 1'b0;
                p2    <= 1'b0;
                if (state == S_IFETCH) begin
                  if_data <= rbuf_next;
                  if_done <= 1'b1;
                end else begin
                  ls_rdata <= rbuf_next;
                  ls_done  <= 1'b1;
                end
              end
            end
          end
        end
        S_STORE: begin
          if (ai == nbytes) begin
            state   <= S_IDLE;
            ls_done <= 1'b1;
          end else if (!stall) begin
            mem_a    <= addr + {29'd0, ai};
            mem_dout <= wdata[{ai[1:0], 3'b000} +: 8];
            mem_wr   <= 1'b1;
            ai       <= ai + 3'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
